// File: rtl/uplink_tx.sv
// ---------------------------------------------------------------------------
// uplink_tx -- serial pulse transmitter for the AGC uplink receiver.
//
// A 15-bit word is accepted on load while ready is high and sent MSB-first
// as a train of pulses: a "one" bit pulses upl1, a "zero" bit pulses upl0.
// Each pulse is PULSE_CYC cycles high followed by GAP_CYC cycles with both
// lines low. done strobes for one cycle (together with ready) when the last
// gap ends; a load in that cycle starts the next word with no idle cycle.
//
// Optional feature (macro UPLINK_TX_TRIPLE_EN): when defined, each word is
// sent three times as word, ~word, word (45 bits). When undefined, only the
// word itself is sent (15 bits).
//
// Parameters:
//   PULSE_CYC  cycles each pulse is held high (>= 1)
//   GAP_CYC    low cycles after each pulse   (>= 1)
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   load       request to transmit data_in
//   data_in    15-bit uplink word, bit 14 is the MSB
//   ready      high while idle (a load is accepted)
//   upl0       registered "zero" pulse line
//   upl1       registered "one" pulse line
//   done       one-cycle strobe at word completion
// ---------------------------------------------------------------------------
module uplink_tx #(
    parameter int PULSE_CYC = 1,
    parameter int GAP_CYC   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [14:0] data_in,
    output logic        ready,
    output logic        upl0,
    output logic        upl1,
    output logic        done
);

`ifdef UPLINK_TX_TRIPLE_EN
    localparam int N = 45;
`else
    localparam int N = 15;
`endif

    localparam int BW   = $clog2(N);
    localparam int PMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [N-1:0]    shift_q, shift_d;
    logic            upl0_q, upl0_d;
    logic            upl1_q, upl1_d;
    logic            done_q, done_d;
    logic [N-1:0]    seq_w;

    // Full bit sequence for the word being loaded, first bit in the MSB.
`ifdef UPLINK_TX_TRIPLE_EN
    assign seq_w = {data_in, ~data_in, data_in};
`else
    assign seq_w = data_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bit_q   <= '0;
            phase_q <= '0;
            shift_q <= '0;
            upl0_q  <= 1'b0;
            upl1_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            shift_q <= shift_d;
            upl0_q  <= upl0_d;
            upl1_q  <= upl1_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        shift_d = shift_q;
        upl0_d  = upl0_q;
        upl1_d  = upl1_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    // The first bit goes straight onto the lines; the rest
                    // wait in the shift register, so later data_in changes
                    // cannot reach the word in flight.
                    state_d = PULSE;
                    bit_d   = '0;
                    phase_d = '0;
                    upl1_d  = seq_w[N-1];
                    upl0_d  = ~seq_w[N-1];
                    shift_d = {seq_w[N-2:0], 1'b0};
                end
            end
            PULSE: begin
                if (phase_q == PW'(PULSE_CYC - 1)) begin
                    state_d = GAP;
                    phase_d = '0;
                    upl0_d  = 1'b0;
                    upl1_d  = 1'b0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            GAP: begin
                if (phase_q == PW'(GAP_CYC - 1)) begin
                    phase_d = '0;
                    if (bit_q == BW'(N - 1)) begin
                        // Last gap over: back to idle, strobe done in the
                        // same cycle ready rises.
                        state_d = IDLE;
                        bit_d   = '0;
                        shift_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = PULSE;
                        bit_d   = bit_q + 1'b1;
                        upl1_d  = shift_q[N-1];
                        upl0_d  = ~shift_q[N-1];
                        shift_d = {shift_q[N-2:0], 1'b0};
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                upl0_d  = 1'b0;
                upl1_d  = 1'b0;
            end
        endcase
    end

    assign ready = (state_q == IDLE);
    assign upl0  = upl0_q;
    assign upl1  = upl1_q;
    assign done  = done_q;

endmodule

// File: tb/tb_uplink_tx.sv
// ---------------------------------------------------------------------------
// tb_uplink_tx -- self-checking bench for uplink_tx.
//
// Two instances share the same inputs: one with default timing (1 high,
// 3 low) and one with PULSE_CYC=2, GAP_CYC=1. A reference model computes
// every expected output from the cycle count since acceptance using plain
// arithmetic (bit index = (c-1)/period, offset = (c-1)%period).
// ---------------------------------------------------------------------------
module tb_uplink_tx;

`ifdef UPLINK_TX_TRIPLE_EN
    localparam int N = 45;
`else
    localparam int N = 15;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [14:0] data_in = '0;
    logic [1:0]  rdy, u0, u1, dn;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    int          pcyc [2] = '{1, 2};
    int          gcyc [2] = '{3, 1};
    bit          act  [2] = '{1'b0, 1'b0};
    int          c    [2] = '{0, 0};
    logic [14:0] w    [2] = '{15'd0, 15'd0};
    int          acc  [2] = '{0, 0};

    always #5 clk = ~clk;

    uplink_tx dut_a (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in),
        .ready(rdy[0]), .upl0(u0[0]), .upl1(u1[0]), .done(dn[0])
    );

    uplink_tx #(.PULSE_CYC(2), .GAP_CYC(1)) dut_b (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in),
        .ready(rdy[1]), .upl0(u0[1]), .upl1(u1[1]), .done(dn[1])
    );

    // Bit k of the transmitted sequence: section 0 = word, 1 = ~word, 2 = word.
    function automatic logic seqbit(input logic [14:0] wd, input int k);
        int   sec;
        int   pos;
        logic b;
        sec = k / 15;
        pos = 14 - (k % 15);
        b   = wd[pos];
        if (sec == 1) b = ~b;
        return b;
    endfunction

    function automatic int busy_cycles(input int d);
        return N * (pcyc[d] + gcyc[d]);
    endfunction

    // Model update at a rising edge, using the inputs held before the edge.
    task automatic model_edge(input int d);
        bit ready_pre;
        ready_pre = !(act[d] && c[d] <= busy_cycles(d));
        if (rst) begin
            act[d] = 1'b0;
            c[d]   = 0;
        end else if (load && ready_pre) begin
            act[d] = 1'b1;
            c[d]   = 1;
            w[d]   = data_in;
            acc[d]++;
            $display("cycle %0d: dut%0d accepted word %o", cyc, d, data_in);
        end else if (act[d]) begin
            if (c[d] == busy_cycles(d) + 1) act[d] = 1'b0;
            else c[d]++;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_dut(input int d);
        logic e_rdy, e_u0, e_u1, e_dn;
        int   per, k, off;
        e_rdy = 1'b1; e_u0 = 1'b0; e_u1 = 1'b0; e_dn = 1'b0;
        per = pcyc[d] + gcyc[d];
        if (act[d] && c[d] <= busy_cycles(d)) begin
            k     = (c[d] - 1) / per;
            off   = (c[d] - 1) % per;
            e_rdy = 1'b0;
            if (off < pcyc[d]) begin
                e_u1 = seqbit(w[d], k);
                e_u0 = ~seqbit(w[d], k);
            end
        end else if (act[d] && c[d] == busy_cycles(d) + 1) begin
            e_dn = 1'b1;
        end
        chk($sformatf("ready%0d", d), rdy[d], e_rdy);
        chk($sformatf("upl0_%0d", d), u0[d], e_u0);
        chk($sformatf("upl1_%0d", d), u1[d], e_u1);
        chk($sformatf("done%0d", d), dn[d], e_dn);
        chk($sformatf("excl%0d", d), u0[d] & u1[d], 1'b0);
        chk($sformatf("done_ready%0d", d), dn[d] & ~rdy[d], 1'b0);
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        cyc++;
        check_dut(0);
        check_dut(1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((act[0] || act[1]) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("timeout_busy", act[0] | act[1], 1'b0);
    endtask

    task automatic send(input logic [14:0] d);
        data_in = d;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Alternating pattern, default timing word completes in cycle N*4+1
        send(15'o52525);
        data_in = 15'h1234;
        wait_idle(400);
        tick();

        // All ones: upl1 only
        send(15'h7FFF);
        wait_idle(400);

        // All zeros: upl0 only
        send(15'h0000);
        wait_idle(400);

        // Back-to-back with load held high
        data_in = 15'h0001;
        load    = 1'b1;
        tick();
        data_in = 15'h4000;
        for (int i = 0; i < 400 && acc[0] < 7; i++) tick();
        load = 1'b0;
        wait_idle(400);

        // Load during a word is ignored
        send(15'o12345);
        for (int i = 0; i < 48; i++) tick();
        send(15'o77777);
        wait_idle(400);

        // Reset mid-word aborts it, then a fresh word goes out in full
        send(15'o70707);
        for (int i = 0; i < 18; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        send(15'o13571);
        wait_idle(400);

        // Reset overriding a load in the same edge
        data_in = 15'h2AAA;
        load    = 1'b1;
        rst     = 1'b1;
        tick();
        rst     = 1'b0;
        load    = 1'b0;
        tick();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            load    = ($urandom_range(0, 3) == 0);
            data_in = 15'($urandom);
            rst     = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst  = 1'b0;
        load = 1'b0;
        wait_idle(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uplink_tx.md
UPLINK_TX -- requirements
Module: uplink_tx

Interface
REQ-001 Parameter PULSE_CYC, default 1, sets the clock cycles each bit pulse is held high; legal values are 1 or more.
REQ-002 Parameter GAP_CYC, default 3, sets the low clock cycles after each pulse; legal values are 1 or more.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port load, input, 1 bit: request to transmit data_in.
REQ-006 Port data_in, input, 15 bits: uplink word, bit 14 is the MSB.
REQ-007 Port ready, output, 1 bit: high when a load is accepted.
REQ-008 Port upl0, output, 1 bit: "zero" pulse line to the AGC uplink receiver.
REQ-009 Port upl1, output, 1 bit: "one" pulse line to the AGC uplink receiver.
REQ-010 Port done, output, 1 bit: one-cycle strobe marking word completion.

Function
REQ-011 A load is accepted on a rising edge where load=1 and ready=1; data_in is captured at that edge, and later changes to data_in do not alter the word in flight.
REQ-012 load while ready=0 shall be ignored, with no queuing.
REQ-013 Transmit sequence, with the macro defined: data_in MSB-first, then ~data_in MSB-first, then data_in MSB-first, for N=45 bits.
REQ-014 Each bit is one pulse: upl1 high for a 1, upl0 high for a 0, held for PULSE_CYC cycles, then GAP_CYC cycles with both lines low.
REQ-015 Numbering the cycle after acceptance as cycle 1, the pulse of bit k (k=0..N-1) starts in cycle 1+k*(PULSE_CYC+GAP_CYC).
REQ-016 upl0 and upl1 are never high in the same cycle; both are registered outputs.
REQ-017 States: IDLE (ready=1), PULSE, GAP.
REQ-018 Transitions: IDLE goes to PULSE on acceptance. PULSE goes to GAP after PULSE_CYC cycles. GAP goes to PULSE after GAP_CYC cycles if bits remain, otherwise to IDLE.
REQ-019 ready is low in cycles 1..N*(PULSE_CYC+GAP_CYC).
REQ-020 In cycle N*(PULSE_CYC+GAP_CYC)+1, done=1 and ready=1 together; done is low in every other cycle.
REQ-021 A load in the done cycle is accepted, giving back-to-back words with no extra idle cycle.
REQ-022 The bit counter and phase counter are wide enough for N-1 and max(PULSE_CYC,GAP_CYC)-1 and never wrap mid-word.

Reset
REQ-023 While rst=1 at a rising edge: state goes to IDLE, ready=1, upl0=0, upl1=0, done=0, and all counters and the word register clear.
REQ-024 rst during a word aborts it at that edge: no further pulses and no done strobe for the aborted word.
REQ-025 rst overrides load in the same edge, so that load is not accepted.

Configuration
REQ-026 Macro UPLINK_TX_TRIPLE_EN: when defined, N=45 with the word, complement, word redundancy of REQ-013.
REQ-027 When UPLINK_TX_TRIPLE_EN is undefined: N=15, data_in only, MSB-first; all other timing rules are unchanged.

Verification
REQ-028 Defaults, macro defined, load data_in=15'o52525 -> 45 pulses ordered 101010101010101 / 010101010101010 / 101010101010101 on upl1/upl0, each 1 cycle wide and 4 cycles apart; done in cycle 181.
REQ-029 PULSE_CYC=2, GAP_CYC=1, macro undefined, data_in=15'h7FFF -> 15 upl1 pulses, each 2 cycles wide; upl0 always low; done in cycle 46.
REQ-030 Hold load=1 continuously with data 15'h0001 then 15'h4000 -> second word's first pulse in the cycle after done; no idle gap; each word is sent exactly once.
REQ-031 Pulse load with new data in cycle 50 of a word -> ignored; word in flight is unchanged; ready stays low until done.
REQ-032 Assert rst for 1 cycle in cycle 20 of a word -> next cycle: upl0=upl1=0, ready=1, no done; a following load sends a full fresh word.
REQ-033 Every cycle of every test -> assertion that upl0&upl1 is 0, and that done implies ready.
